// File: rtl/traffic_gen_pkg.sv
// rtl/traffic_gen_pkg.sv - state encoding, LFSR taps and LFSR step shared by traffic_gen
package traffic_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PUSH,
        GAP,
        POP,
        DONE
    } tg_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/tgen_payload.sv
// rtl/tgen_payload.sv - per-channel payload source; LFSR when TRAFFIC_GEN_LFSR_EN, else counter
module tgen_payload
    import traffic_gen_pkg::*;
#(
    parameter int PW = 8
`ifdef TRAFFIC_GEN_LFSR_EN
    , parameter logic [15:0] SEED_C = 16'h0001
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [PW-1:0] payload
);

`ifdef TRAFFIC_GEN_LFSR_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // The word presented with a push is the already-stepped value.
    always_comb lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED_C;
        end else if (advance) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign payload = PW'(lfsr_d);
`else
    logic [PW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (advance) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign payload = cnt_q;
`endif

endmodule

// File: rtl/traffic_gen.sv
// rtl/traffic_gen.sv - multi-channel IDLE/INIT/PUSH/GAP/POP/DONE stimulus engine
// Payload source selected by TRAFFIC_GEN_LFSR_EN (LFSR) or counter when undefined.
module traffic_gen
    import traffic_gen_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int          DW      = 10,
    parameter int          LIM_W   = 3,
    parameter int          BURST   = 6,
    parameter int          GAP     = 90,
    parameter int          POP_LEN = 5,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LIM_W-1:0]  cfg_limit_low,
    input  logic [LIM_W-1:0]  cfg_limit_high,
    input  logic [NCH-1:0]    full,
    input  logic [NCH-1:0]    empty,
    output logic [NCH*DW-1:0] data_out,
    output logic [NCH-1:0]    push,
    output logic [NCH-1:0]    pop,
    output logic              init,
    output logic [LIM_W-1:0]  limit_low,
    output logic [LIM_W-1:0]  limit_high,
    output logic              done
);

    localparam int TAG_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW    = DW - TAG_W;
    localparam int BCW   = $clog2(BURST + 1);
    localparam int PCW   = $clog2(POP_LEN + 1);
    localparam int GCW   = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BCW-1:0] BURST_C = BCW'(BURST);
    localparam logic [PCW-1:0] POP_C   = PCW'(POP_LEN);
    localparam logic [GCW-1:0] GAP_C   = GCW'(GAP);

    tg_state_e         state_q, state_d;
    logic [NCH-1:0]    push_q, push_d;
    logic [NCH-1:0]    pop_q, pop_d;
    logic [NCH*DW-1:0] data_q, data_d;
    logic              init_q, init_d;
    logic              done_q, done_d;
    logic [LIM_W-1:0]  lim_lo_q, lim_lo_d;
    logic [LIM_W-1:0]  lim_hi_q, lim_hi_d;
    logic [BCW-1:0]    bcnt_q [NCH];
    logic [BCW-1:0]    bcnt_d [NCH];
    logic [PCW-1:0]    pcnt_q [NCH];
    logic [PCW-1:0]    pcnt_d [NCH];
    logic [NCH-1:0]    fin_q, fin_d;
    logic [GCW-1:0]    gap_q, gap_d;
    logic [NCH-1:0]    fin_now;
    logic              all_pushed;
    logic [PW-1:0]     pay [NCH];

    // Output registers are loaded with the values of the state being entered,
    // so a decision taken at edge k is visible in the following cycle.
    always_comb begin
        state_d    = state_q;
        push_d     = '0;
        pop_d      = '0;
        data_d     = '0;
        init_d     = 1'b0;
        done_d     = 1'b0;
        lim_lo_d   = lim_lo_q;
        lim_hi_d   = lim_hi_q;
        fin_d      = fin_q;
        gap_d      = gap_q;
        bcnt_d     = bcnt_q;
        pcnt_d     = pcnt_q;
        all_pushed = 1'b1;
        fin_now    = '0;

        for (int c = 0; c < NCH; c++) begin
            if (bcnt_q[c] != BURST_C) all_pushed = 1'b0;
            // Empty only retires a channel once the pop phase has had a cycle.
            fin_now[c] = fin_q[c] | (pcnt_q[c] == POP_C) | empty[c];
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = INIT;
                    init_d   = 1'b1;
                    lim_lo_d = cfg_limit_low;
                    lim_hi_d = cfg_limit_high;
                    fin_d    = '0;
                    gap_d    = '0;
                    for (int c = 0; c < NCH; c++) begin
                        bcnt_d[c] = '0;
                        pcnt_d[c] = '0;
                    end
                end
            end
            INIT: state_d = PUSH;
            PUSH: begin
                if (all_pushed) begin
                    if (GAP == 0) begin
                        state_d = POP;
                    end else begin
                        state_d = traffic_gen_pkg::GAP;
                        gap_d   = GCW'(1);
                    end
                end
            end
            traffic_gen_pkg::GAP: begin
                if (gap_q == GAP_C) state_d = POP;
                else                gap_d   = gap_q + 1'b1;
            end
            POP: begin
                fin_d = fin_now;
                if (&fin_now) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (start) done_d  = 1'b1;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == PUSH) begin
            for (int c = 0; c < NCH; c++) begin
                if ((bcnt_q[c] < BURST_C) && !full[c]) begin
                    push_d[c]            = 1'b1;
                    bcnt_d[c]            = bcnt_q[c] + 1'b1;
                    data_d[c*DW +: DW]   = {TAG_W'(c), pay[c]};
                end
            end
        end

        if (state_d == POP) begin
            for (int c = 0; c < NCH; c++) begin
                if (!fin_d[c] && (pcnt_q[c] < POP_C) && !empty[c]) begin
                    pop_d[c]  = 1'b1;
                    pcnt_d[c] = pcnt_q[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            push_q   <= '0;
            pop_q    <= '0;
            data_q   <= '0;
            init_q   <= 1'b0;
            done_q   <= 1'b0;
            lim_lo_q <= '0;
            lim_hi_q <= '0;
            fin_q    <= '0;
            gap_q    <= '0;
            for (int c = 0; c < NCH; c++) begin
                bcnt_q[c] <= '0;
                pcnt_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            push_q   <= push_d;
            pop_q    <= pop_d;
            data_q   <= data_d;
            init_q   <= init_d;
            done_q   <= done_d;
            lim_lo_q <= lim_lo_d;
            lim_hi_q <= lim_hi_d;
            fin_q    <= fin_d;
            gap_q    <= gap_d;
            bcnt_q   <= bcnt_d;
            pcnt_q   <= pcnt_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
`ifdef TRAFFIC_GEN_LFSR_EN
        localparam logic [15:0] CH_SEED =
            ((SEED ^ 16'(g)) == 16'h0) ? 16'h0001 : (SEED ^ 16'(g));
        tgen_payload #(.PW(PW), .SEED_C(CH_SEED)) u_payload (
            .clk     (clk),
            .reset   (reset),
            .advance (push_d[g]),
            .payload (pay[g])
        );
`else
        tgen_payload #(.PW(PW)) u_payload (
            .clk     (clk),
            .reset   (reset),
            .advance (push_d[g]),
            .payload (pay[g])
        );
`endif
    end

    assign data_out   = data_q;
    assign push       = push_q;
    assign pop        = pop_q;
    assign init       = init_q;
    assign done       = done_q;
    assign limit_low  = lim_lo_q;
    assign limit_high = lim_hi_q;

endmodule

// File: tb/tb_traffic_gen.sv
// tb/tb_traffic_gen.sv - directed self-checking bench for traffic_gen (default parameters)
module tb_traffic_gen;
    import traffic_gen_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  cfg_lo, cfg_hi;
    logic [3:0]  full, empty;
    logic [39:0] data_out;
    logic [3:0]  push, pop;
    logic        init, done;
    logic [2:0]  limit_low, limit_high;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [15:0] mst [NCH];

    traffic_gen dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_limit_low  (cfg_lo),
        .cfg_limit_high (cfg_hi),
        .full           (full),
        .empty          (empty),
        .data_out       (data_out),
        .push           (push),
        .pop            (pop),
        .init           (init),
        .limit_low      (limit_low),
        .limit_high     (limit_high),
        .done           (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
`ifdef TRAFFIC_GEN_LFSR_EN
            mst[c] = ((16'hACE1 ^ 16'(c)) == 16'h0) ? 16'h0001 : (16'hACE1 ^ 16'(c));
`else
            mst[c] = 16'h0;
`endif
        end
    endtask

    // Checks the strobe vector and every data slice, stepping the payload model on pushes.
    task automatic chk_data(input logic [3:0] exp_push);
        logic [15:0] nx;
        logic [9:0]  exp;
        for (int c = 0; c < NCH; c++) begin
            exp = '0;
            if (exp_push[c]) begin
`ifdef TRAFFIC_GEN_LFSR_EN
                nx     = lfsr_next(mst[c]);
                exp    = {2'(c), nx[7:0]};
                mst[c] = nx;
`else
                nx     = mst[c];
                exp    = {2'(c), nx[7:0]};
                mst[c] = nx + 16'h1;
`endif
            end
            chk($sformatf("data_ch%0d", c), 40'(data_out[c*DW +: DW]), 40'(exp));
        end
        chk("push", 40'(push), 40'(exp_push));
    endtask

    initial begin
        logic [3:0] ep;
        reset = 1'b1; start = 1'b0; cfg_lo = '0; cfg_hi = '0; full = '0; empty = '0;
        tick();
        tick();
        chk("rst_push",   40'(push), 40'h0);
        chk("rst_pop",    40'(pop),  40'h0);
        chk("rst_init",   40'(init), 40'h0);
        chk("rst_done",   40'(done), 40'h0);
        chk("rst_data",   data_out,  40'h0);
        chk("rst_limits", 40'({limit_high, limit_low}), 40'h0);

        // Run 1: nominal sequence, start held high throughout
        reset = 1'b0;
        model_reset();
        start = 1'b1; cfg_lo = 3'd3; cfg_hi = 3'd7; cyc = 0;
        tick();
        chk("init",   40'(init),      40'h1);
        chk("lim_lo", 40'(limit_low), 40'h3);
        chk("lim_hi", 40'(limit_high),40'h7);
        chk_data(4'h0);
        tick();
`ifdef TRAFFIC_GEN_LFSR_EN
        chk("ch0_first", 40'(data_out[9:0]),   40'h070);
        chk("ch1_first", 40'(data_out[19:10]), 40'h170);
`else
        chk("ch0_first", 40'(data_out[9:0]),   40'h000);
        chk("ch3_first", 40'(data_out[39:30]), 40'h300);
`endif
        chk("init_low", 40'(init), 40'h0);
        chk_data(4'hF);
        for (int i = 3; i <= 7; i++) begin
            tick();
            chk_data(4'hF);
        end
`ifndef TRAFFIC_GEN_LFSR_EN
        chk("ch0_last", 40'(data_out[9:0]),   40'h005);
        chk("ch3_last", 40'(data_out[39:30]), 40'h305);
`endif
        tick();
        chk_data(4'h0);
        chk("gap_first_pop", 40'(pop), 40'h0);
        while (cyc < 97) begin
            tick();
            chk("gap_strobes", 40'({push, pop}), 40'h0);
        end
        for (int i = 98; i <= 102; i++) begin
            tick();
            chk("pop",        40'(pop),  40'hF);
            chk("done_early", 40'(done), 40'h0);
        end
        tick();
        chk("done",    40'(done), 40'h1);
        chk("pop_end", 40'(pop),  40'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_hold", 40'(done), 40'h1);
            chk("no_rerun",  40'(init), 40'h0);
        end
        start = 1'b0;
        tick();
        chk("done_clr", 40'(done), 40'h0);
        tick();
        chk("idle_init", 40'(init), 40'h0);

        // Run 2: full[1] back-pressure, empty[2] during pop, payload state carried over
        start = 1'b1; cyc = 0;
        tick();
        chk("init2", 40'(init), 40'h1);
        for (int i = 2; i <= 9; i++) begin
            full[1] = (i == 4 || i == 5);
            tick();
            ep    = (i <= 7) ? 4'hF : 4'h0;
            ep[1] = !(i == 4 || i == 5);
            chk_data(ep);
        end
        full = '0;
        tick();
        chk("gap2_start", 40'({push, pop}), 40'h0);
        empty = 4'b0100;
        while (cyc < 99) tick();
        chk("gap2_end", 40'({push, pop}), 40'h0);
        for (int i = 100; i <= 104; i++) begin
            tick();
            chk("pop2", 40'(pop), 40'hB);
        end
        tick();
        chk("done2", 40'(done), 40'h1);
        start = 1'b0; empty = '0;
        tick();

        // Run 3: reset mid-GAP with start held
        cfg_lo = 3'd5; cfg_hi = 3'd2; start = 1'b1; cyc = 0;
        tick();
        chk("init3", 40'(init), 40'h1);
        while (cyc < 50) tick();
        reset = 1'b1;
        tick();
        chk("rst2_strobes", 40'({push, pop}), 40'h0);
        chk("rst2_flags",   40'({init, done}), 40'h0);
        chk("rst2_data",    data_out, 40'h0);
        chk("rst2_limits",  40'({limit_high, limit_low}), 40'h0);
        reset = 1'b0;
        model_reset();
        tick();
        chk("init_after_rst", 40'(init), 40'h1);
        chk("limits3", 40'({limit_high, limit_low}), 40'({3'd2, 3'd5}));
        tick();
        chk_data(4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
